// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Pipelined immediate generator for the RV32IM decode path. Each accepted
//   instruction is classified by opcode, its sign-extended immediate is
//   assembled, and illegal opcodes are flagged. Results are registered and
//   handed downstream through a valid/ready handshake, optionally behind a
//   2-entry skid buffer so backpressure never costs throughput.
//
// Parameters
//   XLEN      data/PC width (only 32 is supported)
//   USE_SKID  1: 2-entry skid buffer, in_ready registered
//             0: single output register, in_ready = !out_valid || out_ready
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush, drops every held entry
//   in_valid     upstream instruction valid
//   in_ready     stage can accept an instruction this cycle
//   in_ins       raw 32-bit instruction word
//   in_pc        PC of in_ins
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_imm      assembled sign-extended immediate
//   out_fmt      0=R/none 1=I 2=S 3=B 4=U 5=J
//   out_illegal  opcode is not an RV32IM base opcode
//   out_pc       PC travelling with the result
module imm_gen_stage #(
  parameter int XLEN     = 32,
  parameter bit USE_SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // ---- stage p0: combinational decode of the incoming word ----
  logic signed [31:0] imm_p0;
  logic [2:0]         fmt_p0;
  logic               ill_p0;

  always_comb begin
    imm_p0 = '0;
    fmt_p0 = FMT_R;
    ill_p0 = 1'b0;
    case (in_ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        fmt_p0 = FMT_I;
        imm_p0 = {{20{in_ins[31]}}, in_ins[31:20]};
      end
      7'b0100011: begin
        fmt_p0 = FMT_S;
        imm_p0 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      end
      7'b1100011: begin
        fmt_p0 = FMT_B;
        imm_p0 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25],
                  in_ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_p0 = FMT_U;
        imm_p0 = {in_ins[31:12], 12'h000};
      end
      7'b1101111: begin
        fmt_p0 = FMT_J;
        imm_p0 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20],
                  in_ins[30:21], 1'b0};
      end
      7'b0110011: begin
        fmt_p0 = FMT_R;
      end
      // Any other opcode (including low bits != 2'b11) is illegal but still
      // flows through so the stage never stalls on it.
      default: begin
        ill_p0 = 1'b1;
      end
    endcase
  end

  logic acc_p0;
  logic drn_p1;

  assign acc_p0 = in_valid && in_ready;
  assign drn_p1 = out_valid && out_ready;

  // ---- stage p1: output register (plus optional skid entry) ----
  logic                vld_p1;
  logic signed [31:0]  imm_p1;
  logic [2:0]          fmt_p1;
  logic                ill_p1;
  logic [XLEN-1:0]     pc_p1;

  generate
    if (USE_SKID) begin : g_skid
      logic               vld_sk;
      logic signed [31:0] imm_sk;
      logic [2:0]         fmt_sk;
      logic               ill_sk;
      logic [XLEN-1:0]    pc_sk;
      logic               rdy_q;

      logic vld_nxt;
      logic sk_nxt;
      logic ld_out_in;
      logic ld_out_sk;
      logic ld_sk_in;

      // Occupancy is {vld_p1, vld_sk}: EMPTY=00, ONE=10, FULL=11.
      always_comb begin
        vld_nxt   = vld_p1;
        sk_nxt    = vld_sk;
        ld_out_in = 1'b0;
        ld_out_sk = 1'b0;
        ld_sk_in  = 1'b0;
        if (flush) begin
          vld_nxt = 1'b0;
          sk_nxt  = 1'b0;
        end else if (!vld_p1) begin
          if (acc_p0) begin
            vld_nxt   = 1'b1;
            ld_out_in = 1'b1;
          end
        end else if (!vld_sk) begin
          if (acc_p0 && drn_p1) begin
            ld_out_in = 1'b1;
          end else if (acc_p0) begin
            sk_nxt   = 1'b1;
            ld_sk_in = 1'b1;
          end else if (drn_p1) begin
            vld_nxt = 1'b0;
          end
        end else if (drn_p1) begin
          // FULL: in_ready is low, so only a drain can happen here.
          sk_nxt    = 1'b0;
          ld_out_sk = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1 <= 1'b0;
          imm_p1 <= '0;
          fmt_p1 <= '0;
          ill_p1 <= 1'b0;
          pc_p1  <= '0;
          vld_sk <= 1'b0;
          imm_sk <= '0;
          fmt_sk <= '0;
          ill_sk <= 1'b0;
          pc_sk  <= '0;
          rdy_q  <= 1'b0;
        end else begin
          vld_p1 <= vld_nxt;
          vld_sk <= sk_nxt;
          // Registered ready: depends only on next skid occupancy, never
          // on this cycle's out_ready.
          rdy_q  <= !sk_nxt;
          if (ld_out_in) begin
            imm_p1 <= imm_p0;
            fmt_p1 <= fmt_p0;
            ill_p1 <= ill_p0;
            pc_p1  <= in_pc;
          end else if (ld_out_sk) begin
            imm_p1 <= imm_sk;
            fmt_p1 <= fmt_sk;
            ill_p1 <= ill_sk;
            pc_p1  <= pc_sk;
          end
          if (ld_sk_in) begin
            imm_sk <= imm_p0;
            fmt_sk <= fmt_p0;
            ill_sk <= ill_p0;
            pc_sk  <= in_pc;
          end
        end
      end

      assign in_ready = rdy_q;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1 <= 1'b0;
          imm_p1 <= '0;
          fmt_p1 <= '0;
          ill_p1 <= 1'b0;
          pc_p1  <= '0;
        end else if (flush) begin
          vld_p1 <= 1'b0;
        end else if (acc_p0) begin
          vld_p1 <= 1'b1;
          imm_p1 <= imm_p0;
          fmt_p1 <= fmt_p0;
          ill_p1 <= ill_p0;
          pc_p1  <= in_pc;
        end else if (drn_p1) begin
          vld_p1 <= 1'b0;
        end
      end

      assign in_ready = !vld_p1 || out_ready;
    end
  endgenerate

  assign out_valid   = vld_p1;
  assign out_imm     = imm_p1;
  assign out_fmt     = fmt_p1;
  assign out_illegal = ill_p1;
  assign out_pc      = pc_p1;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
//   Self-checking bench for imm_gen_stage: directed decode cases, backpressure,
//   flush, asynchronous reset and a randomized handshake phase, all checked
//   against a behavioural scoreboard model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ins = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .USE_SKID(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ins      (in_ins),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   drained  = 0;

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Immediate values computed as signed integer offsets from bit weights.
  function automatic exp_t ref_model(input logic [31:0] ins,
                                     input logic [31:0] pc);
    exp_t e;
    e.imm = '0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.pc  = pc;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin
        e.fmt = 3'd1;
        e.imm = ins[30:20] - ins[31] * 2048;
      end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = ins[11:7] + ins[30:25] * 32 - ins[31] * 2048;
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = ins[11:8] * 2 + ins[30:25] * 32 + ins[7] * 2048 - ins[31] * 4096;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        e.imm = ins[31:12] * 4096;
      end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = ins[30:21] * 2 + ins[20] * 2048 + ins[19:12] * 4096
                - ins[31] * 1048576;
      end
      7'h33: e.fmt = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    return r;
  endfunction

  // Scoreboard: compare the head entry whenever out_valid is seen, pop on a
  // drain, push on an accept; flush and reset discard everything held.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (out_valid) begin
        check_eq("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          check_eq("sb_imm", 64'(out_imm), 64'(sbq[0].imm));
          check_eq("sb_fmt", 64'(out_fmt), 64'(sbq[0].fmt));
          check_eq("sb_ill", 64'(out_illegal), 64'(sbq[0].ill));
          check_eq("sb_pc", 64'(out_pc), 64'(sbq[0].pc));
          if (out_ready && !flush) begin
            void'(sbq.pop_front());
            drained++;
          end
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back(ref_model(in_ins, in_pc));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_ins   = ins;
    in_pc    = pc;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("send_accepted", 64'(done), 64'd1);
  endtask

  logic [31:0] d_ins [8] = '{32'hFE512E23, 32'hFE000CE3, 32'h123450B7,
                             32'h0010006F, 32'hFFF00093, 32'h02B50533,
                             32'h00000000, 32'h0000007F};
  logic [31:0] d_imm [8] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                             32'h00000800, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
  logic [2:0]  d_fmt [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd0, 3'd0, 3'd0};
  logic        d_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] bp_ins [4] = '{32'h00500093, 32'hFE512E23, 32'h123450B7,
                              32'h0010006F};

  initial begin
    int  idx;
    int  snap;
    bit  acc;

    // Reset state
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_imm", 64'(out_imm), 64'd0);
    check_eq("rst_out_fmt", 64'(out_fmt), 64'd0);
    check_eq("rst_out_illegal", 64'(out_illegal), 64'd0);
    check_eq("rst_out_pc", 64'(out_pc), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rdy_after_rst", 64'(in_ready), 64'd1);

    // Directed decode, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(d_ins[i], 32'(i * 4));
      check_eq("dir_valid", 64'(out_valid), 64'd1);
      check_eq("dir_imm", 64'(out_imm), 64'(d_imm[i]));
      check_eq("dir_fmt", 64'(out_fmt), 64'(d_fmt[i]));
      check_eq("dir_ill", 64'(out_illegal), 64'(d_ill[i]));
      check_eq("dir_pc", 64'(out_pc), 64'(i * 4));
    end
    send(32'h00A00113, 32'h40);
    check_eq("after_illegal_valid", 64'(out_valid), 64'd1);
    check_eq("after_illegal_imm", 64'(out_imm), 64'd10);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: out_ready low for 3 edges while streaming 4 entries
    out_ready = 1'b0;
    idx = 0;
    snap = 0;
    in_valid = 1'b1;
    in_ins = bp_ins[0];
    in_pc = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx < 4) begin
        in_valid = 1'b1;
        in_ins = bp_ins[idx];
        in_pc = 32'(idx * 4);
      end else begin
        in_valid = 1'b0;
      end
      if (c == 2) begin
        check_eq("bp_accepted", 64'(idx), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_valid_held", 64'(out_valid), 64'd1);
        check_eq("bp_pc_held", 64'(out_pc), 64'h0);
        check_eq("bp_imm_held", 64'(out_imm), 64'd5);
        out_ready = 1'b1;
        snap = drained;
      end
      if (c == 6) check_eq("bp_drain_rate", 64'(drained - snap), 64'd4);
    end
    check_eq("bp_all_accepted", 64'(idx), 64'd4);
    check_eq("bp_sb_empty", 64'(sbq.size()), 64'd0);

    // Flush while FULL with a concurrent input
    out_ready = 1'b0;
    send(32'h06400093, 32'h100);
    send(32'h0C800093, 32'h104);
    check_eq("fl_full_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_ins = 32'h12C00093;
    in_pc = 32'h108;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_out_valid", 64'(out_valid), 64'd0);
    check_eq("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(32'hFE512E23, 32'h10C);
    check_eq("fl_next_pc", 64'(out_pc), 64'h10C);
    repeat (2) @(posedge clk);
    #1;
    check_eq("fl_nothing_extra", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h123450B7, 32'h200);
    send(32'h0010006F, 32'h204);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_imm", 64'(out_imm), 64'd0);
    check_eq("arst_fmt", 64'(out_fmt), 64'd0);
    check_eq("arst_pc", 64'(out_pc), 64'd0);
    check_eq("arst_ill", 64'(out_illegal), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hFE000CE3, 32'h300);
    check_eq("arst_first_valid", 64'(out_valid), 64'd1);
    check_eq("arst_first_imm", 64'(out_imm), 64'hFFFFFFF8);
    check_eq("arst_first_pc", 64'(out_pc), 64'h300);
    @(posedge clk);
    #1;

    // Randomized handshake traffic
    in_pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_ins = rand_ins();
        in_pc = in_pc + 32'd4;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rand_sb_empty", 64'(sbq.size()), 64'd0);
    check_eq("rand_out_idle", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
